// File: rtl/bist_signature_checker_pkg.sv
// Shared definitions for the BIST session controller: state encodings,
// default signature width and elaboration-time width helpers.
package bist_defs;

  localparam int SIG_W_DEFAULT = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CLEAR   = 3'd1;
  localparam logic [2:0] ST_RUN     = 3'd2;
  localparam logic [2:0] ST_FLUSH   = 3'd3;
  localparam logic [2:0] ST_COMPARE = 3'd4;

  // Bits needed to hold values 0 .. value-1.
  function automatic int clog2(input int value);
    int width;
    width = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        width = i + 1;
      end
    end
    return width;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/bist_signature_checker_if.sv
// Session request / status bundle between the system test controller
// (master) and the BIST signature checker (slave).
interface bist_signature_checker_if #(
  parameter int SIG_W        = 8,
  parameter int NUM_PATTERNS = 16
);
  import bist_defs::*;

  localparam int PAT_W = clog2(NUM_PATTERNS + 1);

  logic             start;
  logic             abort;
  logic [SIG_W-1:0] sig_in;
  logic             misr_clr;
  logic             tpg_en;
  logic             busy;
  logic             done;
  logic             pass;
  logic [SIG_W-1:0] sig_out;
  logic [PAT_W-1:0] pat_cnt;

  modport master (
    output start, abort, sig_in,
    input  misr_clr, tpg_en, busy, done, pass, sig_out, pat_cnt
  );

  modport slave (
    input  start, abort, sig_in,
    output misr_clr, tpg_en, busy, done, pass, sig_out, pat_cnt
  );

endinterface

// File: rtl/bist_signature_checker_phase_counter.sv
// Loadable down-counter timing each session phase; saturates at zero so the
// controller always sees a terminal count rather than a wrap.
module bist_phase_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bist_signature_checker.sv
// BIST session controller: clears the MISR, runs the pattern source, drains,
// then captures and compares the signature against GOLDEN.
module bist_signature_checker
  import bist_defs::*;
#(
  parameter int               SIG_W        = SIG_W_DEFAULT,
  parameter int               NUM_PATTERNS = 16,
  parameter int               CLR_CYCLES   = 2,
  parameter int               FLUSH_CYCLES = 1,
  parameter logic [SIG_W-1:0] GOLDEN       = SIG_W'(8'hA5)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  bist_signature_checker_if.slave bus
);

  localparam int PAT_W  = clog2(NUM_PATTERNS + 1);
  localparam int PH_MAX = max3(CLR_CYCLES, NUM_PATTERNS, FLUSH_CYCLES);
  localparam int CNT_W  = clog2(PH_MAX + 1);

  // Phase counter holds "cycles remaining minus one" so zero marks the last cycle.
  localparam logic [CNT_W-1:0] CLR_LOAD   = CNT_W'(CLR_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LOAD   = CNT_W'(NUM_PATTERNS - 1);
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);
  localparam logic [PAT_W-1:0] PAT_ONE    = PAT_W'(1);

  logic [2:0]       state_q, state_d;
  logic             misr_clr_q, misr_clr_d;
  logic             tpg_en_q, tpg_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [SIG_W-1:0] sig_out_q, sig_out_d;
  logic [PAT_W-1:0] pat_cnt_q, pat_cnt_d;

  logic             ph_load;
  logic             ph_en;
  logic [CNT_W-1:0] ph_load_val;
  logic             ph_zero;

  logic             session_start;
  logic             session_abort;

  assign session_start = (state_q == ST_IDLE) && bus.start && !bus.abort;
  assign session_abort = (state_q != ST_IDLE) && bus.abort;

  bist_phase_counter #(
    .WIDTH (CNT_W)
  ) u_phase_counter (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (ph_load),
    .en_i       (ph_en),
    .load_val_i (ph_load_val),
    .zero_o     (ph_zero)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      misr_clr_q <= 1'b0;
      tpg_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      sig_out_q  <= '0;
      pat_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      misr_clr_q <= misr_clr_d;
      tpg_en_q   <= tpg_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      sig_out_q  <= sig_out_d;
      pat_cnt_q  <= pat_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ph_load     = 1'b0;
    ph_en       = 1'b0;
    ph_load_val = '0;
    case (state_q)
      ST_IDLE: begin
        if (session_start) begin
          state_d     = ST_CLEAR;
          ph_load     = 1'b1;
          ph_load_val = CLR_LOAD;
        end
      end
      ST_CLEAR: begin
        if (session_abort) begin
          state_d = ST_IDLE;
        end else if (ph_zero) begin
          state_d     = ST_RUN;
          ph_load     = 1'b1;
          ph_load_val = RUN_LOAD;
        end else begin
          ph_en = 1'b1;
        end
      end
      ST_RUN: begin
        if (session_abort) begin
          state_d = ST_IDLE;
        end else if (ph_zero) begin
          ph_load = 1'b1;
          if (FLUSH_CYCLES > 0) begin
            state_d     = ST_FLUSH;
            ph_load_val = FLUSH_LOAD;
          end else begin
            state_d = ST_COMPARE;
          end
        end else begin
          ph_en = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (session_abort) begin
          state_d = ST_IDLE;
        end else if (ph_zero) begin
          state_d = ST_COMPARE;
          ph_load = 1'b1;
        end else begin
          ph_en = 1'b1;
        end
      end
      ST_COMPARE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they align with state_q.
  always_comb begin
    misr_clr_d = (state_d == ST_CLEAR);
    tpg_en_d   = (state_d == ST_RUN);
    busy_d     = (state_d != ST_IDLE);
    done_d     = 1'b0;
    pass_d     = pass_q;
    sig_out_d  = sig_out_q;
    pat_cnt_d  = pat_cnt_q;
    if (session_start) begin
      pass_d    = 1'b0;
      sig_out_d = '0;
      pat_cnt_d = '0;
    end else if (session_abort) begin
      pass_d = 1'b0;
    end else begin
      if (state_q == ST_RUN) begin
        pat_cnt_d = pat_cnt_q + PAT_ONE;
      end
      if (state_q == ST_COMPARE) begin
        done_d    = 1'b1;
        sig_out_d = bus.sig_in;
        pass_d    = (bus.sig_in == GOLDEN);
      end
    end
  end

  assign bus.misr_clr = misr_clr_q;
  assign bus.tpg_en   = tpg_en_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.sig_out  = sig_out_q;
  assign bus.pat_cnt  = pat_cnt_q;

endmodule

// File: tb/tb_bist_signature_checker.sv
// Bench for two checker instances (default timing and the 1/1/0 corner),
// each shadowed by a session-offset model compared every cycle.
module tb_bist_signature_checker;
  import bist_defs::*;

  localparam logic [7:0] GOLD = 8'hA5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  bist_signature_checker_if #(.SIG_W(8), .NUM_PATTERNS(16)) bus_a ();
  bist_signature_checker_if #(.SIG_W(8), .NUM_PATTERNS(1))  bus_b ();

  bist_signature_checker #(
    .SIG_W(8), .NUM_PATTERNS(16), .CLR_CYCLES(2), .FLUSH_CYCLES(1), .GOLDEN(8'hA5)
  ) dut_a (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_a)
  );

  bist_signature_checker #(
    .SIG_W(8), .NUM_PATTERNS(1), .CLR_CYCLES(1), .FLUSH_CYCLES(0), .GOLDEN(8'hA5)
  ) dut_b (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pat_of(input int t, input int clr, input int num);
    if (t < clr) return 0;
    if (t - clr > num) return num;
    return t - clr;
  endfunction

  logic       in_start [2];
  logic       in_abort [2];
  logic [7:0] in_sig   [2];
  logic       act_misr [2], act_tpg [2], act_busy [2], act_done [2], act_pass [2];
  logic [7:0] act_sig  [2];
  int         act_pat  [2];
  logic       exp_misr [2], exp_tpg [2], exp_busy [2], exp_done [2], exp_pass [2];
  logic [7:0] exp_sig  [2];
  int         exp_pat  [2];

  assign in_start[0] = bus_a.start;
  assign in_abort[0] = bus_a.abort;
  assign in_sig[0]   = bus_a.sig_in;
  assign in_start[1] = bus_b.start;
  assign in_abort[1] = bus_b.abort;
  assign in_sig[1]   = bus_b.sig_in;

  assign act_misr[0] = bus_a.misr_clr;
  assign act_tpg[0]  = bus_a.tpg_en;
  assign act_busy[0] = bus_a.busy;
  assign act_done[0] = bus_a.done;
  assign act_pass[0] = bus_a.pass;
  assign act_sig[0]  = bus_a.sig_out;
  assign act_pat[0]  = int'(bus_a.pat_cnt);
  assign act_misr[1] = bus_b.misr_clr;
  assign act_tpg[1]  = bus_b.tpg_en;
  assign act_busy[1] = bus_b.busy;
  assign act_done[1] = bus_b.done;
  assign act_pass[1] = bus_b.pass;
  assign act_sig[1]  = bus_b.sig_out;
  assign act_pat[1]  = int'(bus_b.pat_cnt);

  // Model: outputs follow from t = edges elapsed since the session start edge.
  for (genvar gi = 0; gi < 2; gi++) begin : g_model
    localparam int CLR  = (gi == 0) ? 2 : 1;
    localparam int NUM  = (gi == 0) ? 16 : 1;
    localparam int FL   = (gi == 0) ? 1 : 0;
    localparam int LAST = CLR + NUM + FL;

    logic       active;
    logic       done_m;
    logic       pass_m;
    logic [7:0] sig_m;
    int         t;
    int         pat_hold;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        active   <= 1'b0;
        done_m   <= 1'b0;
        pass_m   <= 1'b0;
        sig_m    <= 8'h00;
        t        <= 0;
        pat_hold <= 0;
      end else begin
        done_m <= 1'b0;
        if (active) begin
          if (in_abort[gi]) begin
            active   <= 1'b0;
            pass_m   <= 1'b0;
            pat_hold <= pat_of(t, CLR, NUM);
          end else if (t == LAST) begin
            active   <= 1'b0;
            done_m   <= 1'b1;
            pass_m   <= (in_sig[gi] == GOLD);
            sig_m    <= in_sig[gi];
            pat_hold <= NUM;
          end else begin
            t <= t + 1;
          end
        end else if (in_start[gi] && !in_abort[gi]) begin
          active   <= 1'b1;
          t        <= 0;
          pass_m   <= 1'b0;
          sig_m    <= 8'h00;
          pat_hold <= 0;
        end
      end
    end

    assign exp_busy[gi] = active;
    assign exp_misr[gi] = active && (t < CLR);
    assign exp_tpg[gi]  = active && (t >= CLR) && (t < CLR + NUM);
    assign exp_pat[gi]  = active ? pat_of(t, CLR, NUM) : pat_hold;
    assign exp_done[gi] = done_m;
    assign exp_pass[gi] = pass_m;
    assign exp_sig[gi]  = sig_m;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("dut%0d misr_clr", d), 32'(act_misr[d]), 32'(exp_misr[d]));
        check($sformatf("dut%0d tpg_en", d),   32'(act_tpg[d]),  32'(exp_tpg[d]));
        check($sformatf("dut%0d busy", d),     32'(act_busy[d]), 32'(exp_busy[d]));
        check($sformatf("dut%0d done", d),     32'(act_done[d]), 32'(exp_done[d]));
        check($sformatf("dut%0d pass", d),     32'(act_pass[d]), 32'(exp_pass[d]));
        check($sformatf("dut%0d sig_out", d),  32'(act_sig[d]),  32'(exp_sig[d]));
        check($sformatf("dut%0d pat_cnt", d),  32'(act_pat[d]),  32'(exp_pat[d]));
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  int done_cnt_a = 0, done_edge_a = -1, tpg_cnt_a = 0, misr_cnt_a = 0;
  int done_cnt_b = 0, done_edge_b = -1, tpg_cnt_b = 0, misr_cnt_b = 0;

  always @(negedge clk) begin
    done_cnt_a <= done_cnt_a + int'(bus_a.done);
    tpg_cnt_a  <= tpg_cnt_a + int'(bus_a.tpg_en);
    misr_cnt_a <= misr_cnt_a + int'(bus_a.misr_clr);
    if (bus_a.done) done_edge_a <= cyc - 1;
    done_cnt_b <= done_cnt_b + int'(bus_b.done);
    tpg_cnt_b  <= tpg_cnt_b + int'(bus_b.tpg_en);
    misr_cnt_b <= misr_cnt_b + int'(bus_b.misr_clr);
    if (bus_b.done) done_edge_b <= cyc - 1;
  end

  // Pulses start for one edge; k returns the index of the sampling edge.
  task automatic start_s(input int d, input logic [7:0] sig, output int k);
    @(negedge clk);
    if (d == 0) begin
      bus_a.sig_in = sig;
      bus_a.start  = 1'b1;
    end else begin
      bus_b.sig_in = sig;
      bus_b.start  = 1'b1;
    end
    k = cyc;
    @(negedge clk);
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
  endtask

  task automatic check_a_zero(input string tag);
    check({tag, " busy"},     32'(bus_a.busy), 0);
    check({tag, " misr_clr"}, 32'(bus_a.misr_clr), 0);
    check({tag, " tpg_en"},   32'(bus_a.tpg_en), 0);
    check({tag, " done"},     32'(bus_a.done), 0);
    check({tag, " pass"},     32'(bus_a.pass), 0);
    check({tag, " sig_out"},  32'(bus_a.sig_out), 0);
    check({tag, " pat_cnt"},  32'(bus_a.pat_cnt), 0);
  endtask

  int k, d0, t0, m0;

  initial begin
    rst_n = 1'b0;
    bus_a.start = 1'b0; bus_a.abort = 1'b0; bus_a.sig_in = 8'h00;
    bus_b.start = 1'b0; bus_b.abort = 1'b0; bus_b.sig_in = 8'h00;
    #1;
    check_a_zero("reset");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Golden match
    d0 = done_cnt_a; t0 = tpg_cnt_a; m0 = misr_cnt_a;
    start_s(0, GOLD, k);
    repeat (22) @(negedge clk);
    #1;
    check("golden done_edge", done_edge_a - k, 20);
    check("golden done_pulses", done_cnt_a - d0, 1);
    check("golden tpg_cycles", tpg_cnt_a - t0, 16);
    check("golden misr_cycles", misr_cnt_a - m0, 2);
    check("golden pass", 32'(bus_a.pass), 1);
    check("golden sig_out", 32'(bus_a.sig_out), 32'h A5);
    check("golden pat_cnt", 32'(bus_a.pat_cnt), 16);
    check("golden busy", 32'(bus_a.busy), 0);
    $display("session golden: done_edge=+%0d pass=%0b sig=%02h pat=%0d", done_edge_a - k, bus_a.pass, bus_a.sig_out, bus_a.pat_cnt);

    // Mismatch; pass from the previous session must clear at the start edge
    d0 = done_cnt_a;
    start_s(0, 8'h5A, k);
    #1;
    check("restart pass_cleared", 32'(bus_a.pass), 0);
    check("restart sig_cleared", 32'(bus_a.sig_out), 0);
    check("restart busy", 32'(bus_a.busy), 1);
    repeat (22) @(negedge clk);
    #1;
    check("mismatch done_edge", done_edge_a - k, 20);
    check("mismatch done_pulses", done_cnt_a - d0, 1);
    check("mismatch pass", 32'(bus_a.pass), 0);
    check("mismatch sig_out", 32'(bus_a.sig_out), 32'h5A);
    $display("session mismatch: done_edge=+%0d pass=%0b sig=%02h pat=%0d", done_edge_a - k, bus_a.pass, bus_a.sig_out, bus_a.pat_cnt);

    // start pulses during RUN are ignored
    d0 = done_cnt_a;
    start_s(0, GOLD, k);
    repeat (6) @(negedge clk);
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    repeat (3) @(negedge clk);
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    repeat (14) @(negedge clk);
    #1;
    check("collide done_edge", done_edge_a - k, 20);
    check("collide done_pulses", done_cnt_a - d0, 1);
    check("collide pass", 32'(bus_a.pass), 1);
    $display("session collide: done_edge=+%0d pass=%0b sig=%02h pat=%0d", done_edge_a - k, bus_a.pass, bus_a.sig_out, bus_a.pat_cnt);

    // Abort in RUN at pat_cnt = 7
    d0 = done_cnt_a;
    start_s(0, GOLD, k);
    for (int i = 0; i < 40; i++) begin
      if (bus_a.pat_cnt == 5'd7) break;
      @(negedge clk);
    end
    check("abort wait_pat7", 32'(bus_a.pat_cnt), 7);
    bus_a.abort = 1'b1;
    @(negedge clk);
    bus_a.abort = 1'b0;
    #1;
    check("abort busy", 32'(bus_a.busy), 0);
    check("abort tpg_en", 32'(bus_a.tpg_en), 0);
    check("abort pat_cnt", 32'(bus_a.pat_cnt), 7);
    check("abort pass", 32'(bus_a.pass), 0);
    check("abort sig_out", 32'(bus_a.sig_out), 0);
    repeat (25) @(negedge clk);
    #1;
    check("abort no_done", done_cnt_a - d0, 0);
    check("abort pat_frozen", 32'(bus_a.pat_cnt), 7);
    $display("session abort_run: pat=%0d busy=%0b", bus_a.pat_cnt, bus_a.busy);

    // Abort sampled on the COMPARE closing edge
    d0 = done_cnt_a;
    start_s(0, GOLD, k);
    repeat (19) @(negedge clk);
    bus_a.abort = 1'b1;
    @(negedge clk);
    bus_a.abort = 1'b0;
    #1;
    check("abort_cmp done", 32'(bus_a.done), 0);
    check("abort_cmp busy", 32'(bus_a.busy), 0);
    check("abort_cmp pass", 32'(bus_a.pass), 0);
    check("abort_cmp sig_out", 32'(bus_a.sig_out), 0);
    check("abort_cmp pat_cnt", 32'(bus_a.pat_cnt), 16);
    repeat (3) @(negedge clk);
    #1;
    check("abort_cmp no_done", done_cnt_a - d0, 0);
    $display("session abort_compare: pass=%0b pat=%0d", bus_a.pass, bus_a.pat_cnt);

    // start and abort together in IDLE
    @(negedge clk);
    bus_a.start = 1'b1;
    bus_a.abort = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    bus_a.abort = 1'b0;
    #1;
    check("start_abort busy", 32'(bus_a.busy), 0);
    check("start_abort misr_clr", 32'(bus_a.misr_clr), 0);
    $display("session start_abort_idle: busy=%0b", bus_a.busy);

    // Asynchronous reset mid-session after a passing result
    start_s(0, GOLD, k);
    repeat (22) @(negedge clk);
    start_s(0, GOLD, k);
    repeat (8) @(negedge clk);
    #1;
    check("pre_reset busy", 32'(bus_a.busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check_a_zero("async_reset");
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("post_reset busy", 32'(bus_a.busy), 0);
    check("post_reset misr_clr", 32'(bus_a.misr_clr), 0);
    $display("session reset: busy=%0b pass=%0b", bus_a.busy, bus_a.pass);

    // Parameter corner: CLR=1, NUM=1, FLUSH=0
    d0 = done_cnt_b; t0 = tpg_cnt_b; m0 = misr_cnt_b;
    start_s(1, GOLD, k);
    repeat (6) @(negedge clk);
    #1;
    check("corner done_edge", done_edge_b - k, 3);
    check("corner done_pulses", done_cnt_b - d0, 1);
    check("corner tpg_cycles", tpg_cnt_b - t0, 1);
    check("corner misr_cycles", misr_cnt_b - m0, 1);
    check("corner pass", 32'(bus_b.pass), 1);
    check("corner sig_out", 32'(bus_b.sig_out), 32'hA5);
    check("corner pat_cnt", 32'(bus_b.pat_cnt), 1);
    $display("session corner_gold: done_edge=+%0d pass=%0b sig=%02h", done_edge_b - k, bus_b.pass, bus_b.sig_out);

    start_s(1, 8'h3C, k);
    repeat (6) @(negedge clk);
    #1;
    check("corner2 done_edge", done_edge_b - k, 3);
    check("corner2 pass", 32'(bus_b.pass), 0);
    check("corner2 sig_out", 32'(bus_b.sig_out), 32'h3C);
    $display("session corner_mismatch: done_edge=+%0d pass=%0b sig=%02h", done_edge_b - k, bus_b.pass, bus_b.sig_out);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
